// File: rtl/cpu_mem_pkg.sv
// Shared memory-map constants and the switch-loader state encoding used by
// the CPU / dual-port memory glue logic.
package cpu_mem_pkg;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 32;
    localparam int CPU_DATA_W = 13;
    localparam int SW_ADDR    = 1022;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        ISSUE = 2'd2
    } loader_state_t;

endpackage : cpu_mem_pkg

// File: rtl/sw_debounce.sv
// Switch bank debouncer: two-flop synchroniser, stability counter, accepted
// (stable) value register and a one-cycle change pulse. The change pulse is
// high in the first cycle in which sw_stable already shows the new value.
module sw_debounce #(
    parameter int SW_W      = 3,
    parameter int DB_CYCLES = 50000,
    parameter int DB_CNT_W  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SW_W-1:0] sw_raw,
    output logic [SW_W-1:0] sw_stable,
    output logic            change
);

    logic [SW_W-1:0]     sync1_q, sync2_q;
    logic [SW_W-1:0]     stable_q, stable_d;
    logic [DB_CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic                change_q, change_d;

    // Counter runs while the synchronised input disagrees with the accepted
    // value; reaching the threshold accepts the new value and clears itself,
    // so the counter can never wrap.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        change_d = 1'b0;
        if (sync2_q == stable_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_CNT_W'(DB_CYCLES - 1)) begin
            stable_d = sync2_q;
            db_cnt_d = '0;
            change_d = 1'b1;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    // Reset loads the raw switches everywhere so no change fires afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= sw_raw;
            sync2_q  <= sw_raw;
            stable_q <= sw_raw;
            db_cnt_q <= '0;
            change_q <= 1'b0;
        end else begin
            sync1_q  <= sw_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            db_cnt_q <= db_cnt_d;
            change_q <= change_d;
        end
    end

    assign sw_stable = stable_q;
    assign change    = change_q;

endmodule : sw_debounce

// File: rtl/switch_ram_loader.sv
// Port-A front end of the dual-port memory: registers CPU write requests
// with one cycle of latency and writes the debounced switch value to the
// switch mailbox word during reset.
// Optional macro SW_LIVE_UPDATE_EN: when defined, the mailbox is rewritten
// whenever the debounced value changes, deferred until the CPU is idle.
// When undefined, only the reset-time mailbox write happens.
module switch_ram_loader #(
    parameter int ADDR_W     = cpu_mem_pkg::ADDR_W,
    parameter int DATA_W     = cpu_mem_pkg::DATA_W,
    parameter int CPU_DATA_W = cpu_mem_pkg::CPU_DATA_W,
    parameter int SW_W       = 3,
    parameter int SW_ADDR    = cpu_mem_pkg::SW_ADDR,
    parameter int DB_CYCLES  = 50000,
    parameter int DB_CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SW_W-1:0]       switch,
    input  logic                  cpu_idle,
    input  logic                  cpu_wr_en,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [CPU_DATA_W-1:0] cpu_wdata,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_din,
    output logic [SW_W-1:0]       sw_stable,
    output logic                  load_busy
);

    import cpu_mem_pkg::*;

    logic              sw_change;
    logic              issue;
    logic [SW_W-1:0]   issue_val;

    logic              mem_we_q,   mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q,  mem_din_d;

    sw_debounce #(
        .SW_W      (SW_W),
        .DB_CYCLES (DB_CYCLES),
        .DB_CNT_W  (DB_CNT_W)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .sw_raw    (switch),
        .sw_stable (sw_stable),
        .change    (sw_change)
    );

`ifdef SW_LIVE_UPDATE_EN
    loader_state_t   state_q, state_d;
    logic [SW_W-1:0] pend_val_q, pend_val_d;

    // Loader FSM: capture each accepted switch change, wait for a cycle in
    // which the CPU leaves port A alone, then issue a single mailbox write.
    // A newer change always overwrites the pending value.
    always_comb begin
        state_d    = state_q;
        pend_val_d = pend_val_q;
        if (sw_change) begin
            pend_val_d = sw_stable;
        end
        case (state_q)
            IDLE: begin
                if (sw_change) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (cpu_idle && !cpu_wr_en) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = sw_change ? PEND : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset drops any pending mailbox write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pend_val_q <= '0;
        end else begin
            state_q    <= state_d;
            pend_val_q <= pend_val_d;
        end
    end

    assign issue     = (state_q == ISSUE);
    assign issue_val = pend_val_q;
    assign load_busy = (state_q != IDLE);
`else
    // Live updates are compiled out: these inputs only feed status logic.
    logic unused_live_inputs;
    assign unused_live_inputs = cpu_idle ^ sw_change;

    assign issue     = 1'b0;
    assign issue_val = '0;
    assign load_busy = 1'b0;
`endif

    // Port-A mux: the mailbox write owns the port in its issue cycle,
    // otherwise the CPU request passes through with zero-extended data.
    always_comb begin
        mem_we_d   = cpu_wr_en;
        mem_addr_d = cpu_addr;
        mem_din_d  = DATA_W'(cpu_wdata);
        if (issue) begin
            mem_we_d   = 1'b1;
            mem_addr_d = ADDR_W'(SW_ADDR);
            mem_din_d  = DATA_W'(issue_val);
        end
    end

    // Port-A register; every reset cycle writes the raw switches to the mailbox.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= ADDR_W'(SW_ADDR);
            mem_din_q  <= DATA_W'(switch);
        end else begin
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
        end
    end

    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;

endmodule : switch_ram_loader

// File: tb/tb_switch_ram_loader.sv
// Scoreboard bench for switch_ram_loader: expected port-A writes are queued
// by the stimulus; a negedge monitor pops and checks every mem_we cycle.
module tb_switch_ram_loader;

`ifdef SW_LIVE_UPDATE_EN
    localparam bit LIVE = 1'b1;
`else
    localparam bit LIVE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  switch;
    logic        cpu_idle;
    logic        cpu_wr_en;
    logic [9:0]  cpu_addr;
    logic [12:0] cpu_wdata;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din;
    logic [2:0]  sw_stable;
    logic        load_busy;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] din;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    always #5 clk = ~clk;

    switch_ram_loader #(
        .DB_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .switch    (switch),
        .cpu_idle  (cpu_idle),
        .cpu_wr_en (cpu_wr_en),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .sw_stable (sw_stable),
        .load_busy (load_busy)
    );

    // Monitor: every port-A write must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got addr=%0d din=%h, required no write",
                         mem_addr, mem_din);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_din !== e.din) begin
                    n_err++;
                    $display("FAIL port_a_write: got addr=%0d din=%h, required addr=%0d din=%h",
                             mem_addr, mem_din, e.addr, e.din);
                end else begin
                    $display("write ok: addr=%0d din=%h", mem_addr, mem_din);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [9:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.din  = d;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else begin
            $display("check ok: %s = %h", name, act);
        end
    endtask

    task automatic cpu_write(input logic [9:0] a, input logic [12:0] d);
        cpu_wr_en = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        expect_wr(a, {19'd0, d});
        step();
        cpu_wr_en = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
    endtask

    initial begin
        // 1. reset load: three reset cycles, each writing 5 to the mailbox
        rst       = 1'b1;
        switch    = 3'b101;
        cpu_idle  = 1'b0;
        cpu_wr_en = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        repeat (3) expect_wr(10'd1022, 32'd5);
        repeat (3) step();
        rst = 1'b0;
        check("reset_sw_stable", 32'(sw_stable), 32'd5);
        check("reset_load_busy", 32'(load_busy), 32'd0);
        step();
        check("post_reset_we", 32'(mem_we), 32'd0);

        // 2. CPU passthrough, including address/data extremes
        cpu_write(10'd101, 13'h1ABC);
        cpu_write(10'd0, 13'h1FFF);
        cpu_write(10'd1023, 13'h0001);
        step();
        check("idle_we", 32'(mem_we), 32'd0);

        // 3. debounce reject: 3-cycle glitch to 2
        cpu_idle = 1'b1;
        switch   = 3'd2;
        repeat (3) step();
        switch = 3'd5;
        repeat (10) step();
        check("glitch_sw_stable", 32'(sw_stable), 32'd5);
        check("glitch_load_busy", 32'(load_busy), 32'd0);

        // 4. live update: held change accepted after 2 + 4 cycles
        switch = 3'd2;
        repeat (5) step();
        check("db_before_thresh", 32'(sw_stable), 32'd5);
        step();
        check("db_at_thresh", 32'(sw_stable), 32'd2);
        step();
        check("live_busy", 32'(load_busy), 32'(LIVE));
        if (LIVE) expect_wr(10'd1022, 32'd2);
        repeat (8) step();
        check("live_done_busy", 32'(load_busy), 32'd0);

        // 5. deferred write: CPU busy, value changes 6 then 7
        cpu_idle = 1'b0;
        switch   = 3'd6;
        repeat (10) step();
        check("defer_sw6", 32'(sw_stable), 32'd6);
        check("defer_busy_a", 32'(load_busy), 32'(LIVE));
        cpu_write(10'd200, 13'h0055);
        repeat (9) step();
        check("defer_busy_b", 32'(load_busy), 32'(LIVE));
        switch = 3'd7;
        repeat (8) step();
        check("defer_sw7", 32'(sw_stable), 32'd7);
        check("defer_busy_c", 32'(load_busy), 32'(LIVE));
        if (LIVE) expect_wr(10'd1022, 32'd7);
        cpu_idle = 1'b1;
        repeat (6) step();
        check("defer_done_busy", 32'(load_busy), 32'd0);

        // 6. reset while a write is pending
        cpu_idle = 1'b0;
        switch   = 3'd4;
        repeat (8) step();
        check("pend_busy", 32'(load_busy), 32'(LIVE));
        switch = 3'b011;
        rst    = 1'b1;
        repeat (2) expect_wr(10'd1022, 32'd3);
        repeat (2) step();
        rst = 1'b0;
        step();
        check("rst_pend_busy", 32'(load_busy), 32'd0);
        check("rst_pend_sw", 32'(sw_stable), 32'd3);
        check("rst_pend_we", 32'(mem_we), 32'd0);
        cpu_idle = 1'b1;
        repeat (10) step();
        check("rst_pend_idle_busy", 32'(load_busy), 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_switch_ram_loader

// File: doc/switch_ram_loader.md
Name: switch_ram_loader

Overview:
- Sits between SimpleCPU and port A of the dual-port memory, replacing the inline port-A register stage in the top level.
- Registers CPU write requests (address, data, write enable) onto port A with one cycle of latency.
- Debounces the 3-bit switch bank. Writes the switch value to the switch mailbox word at reset.
- Re-writes the mailbox whenever the debounced value changes and the CPU is idle.

Parameters:
- ADDR_W, 10, memory address width
- DATA_W, 32, memory data width
- CPU_DATA_W, 13, width of CPU write data; zero-extended to DATA_W
- SW_W, 3, switch bank width
- SW_ADDR, 1022, mailbox word address for the switch value
- DB_CYCLES, 50000, cycles an input must stay stable before it is accepted
- DB_CNT_W, 16, debounce counter width; must satisfy DB_CYCLES < 2**DB_CNT_W

Ports:
- clk, in, 1, system clock
- rst, in, 1, reset; synchronous, active-high
- switch, in, SW_W, raw asynchronous switches
- cpu_idle, in, 1, high when the CPU is not accessing memory this cycle; tie to 0 to disable live updates
- cpu_wr_en, in, 1, CPU write enable
- cpu_addr, in, ADDR_W, CPU address (read or write)
- cpu_wdata, in, CPU_DATA_W, CPU write data
- mem_we, out, 1, port A write enable (registered)
- mem_addr, out, ADDR_W, port A address (registered)
- mem_din, out, DATA_W, port A write data (registered)
- sw_stable, out, SW_W, current debounced switch value
- load_busy, out, 1, high while a mailbox write is pending or issuing

Behaviour:
- Reset, every cycle rst=1:
  - mem_we=1, mem_addr=SW_ADDR, mem_din=zero-extended raw switch.
  - sync1, sync2 and sw_stable all load the raw switch value, so no spurious change fires after reset.
  - db_cnt=0; FSM goes to IDLE; load_busy=0.
- Synchroniser: two flops, sync1 then sync2. The debouncer only sees sync2.
- Debounce:
  - If sync2 == sw_stable, db_cnt is cleared.
  - Otherwise db_cnt increments.
  - When db_cnt == DB_CYCLES-1 and sync2 still differs, sw_stable <= sync2, db_cnt <= 0, and the change flag pulses for 1 cycle.
  - A glitch shorter than DB_CYCLES has no effect.
  - The counter never wraps, because it is cleared at the threshold.
- FSM:
  - IDLE: on the change flag, latch pend_val <= new sw_stable and go to PEND.
  - PEND: when cpu_idle=1 and cpu_wr_en=0, go to ISSUE. Otherwise stay in PEND.
  - ISSUE: port A gets we=1, addr=SW_ADDR, din=zero-extended pend_val for exactly one cycle; then return to IDLE.
  - If a new change flag fires while in PEND, pend_val is overwritten and only the latest value is written.
  - If a change flag fires in the ISSUE cycle, pend_val updates and the FSM goes to PEND instead of IDLE.
- Port A mux, registered, 1-cycle latency:
  - The ISSUE cycle takes the port.
  - Every other cycle: mem_we<=cpu_wr_en, mem_addr<=cpu_addr, mem_din<={zeros,cpu_wdata}.
  - The CPU always wins when cpu_idle=0; a pending write waits indefinitely.
- load_busy = (state != IDLE).
- Reset mid-operation, in PEND or ISSUE: the pending write is dropped; the reset write of the raw switch takes its place.
- Reads are not registered here; memory douta returns straight to the CPU.

Optional Feature:
- Macro SW_LIVE_UPDATE_EN.
- Defined: the debouncer and FSM operate as described above.
- Not defined:
  - Only the reset-time mailbox write occurs.
  - The FSM stays in IDLE; load_busy=0; cpu_idle is ignored.
  - Port A is a pure 1-cycle register of the CPU signals.
  - sw_stable still tracks the debounced switches, as a status output only.

Decomposition:
- Shared package, cpu_mem_pkg: SW_ADDR, ADDR_W, DATA_W, CPU_DATA_W constants, and the loader state enum (IDLE, PEND, ISSUE).
- One sub-module: sw_debounce, holding the synchroniser, counter, stable register and change pulse, parameterised by SW_W, DB_CYCLES and DB_CNT_W.
- The FSM and port mux stay in switch_ram_loader.

Test Plan:
1. Reset load: DB_CYCLES=4, switch=3'b101, rst high 3 cycles -> every reset cycle shows mem_we=1, mem_addr=1022, mem_din=32'd5; after release, port A follows the CPU one cycle later.
2. CPU passthrough: cpu_wr_en=1, addr=101, wdata=13'h1ABC, cpu_idle=0 -> next cycle mem_we=1, mem_addr=101, mem_din=32'h00001ABC.
3. Debounce reject: switch toggles 5 -> 2 for 3 cycles, then back to 5, with cpu_idle=1 -> sw_stable stays 5; no write to 1022; load_busy=0.
4. Live update: switch 5 -> 2 held, cpu_idle=1, cpu_wr_en=0 -> sw_stable=2 after 2 sync + 4 debounce cycles; exactly one cycle with mem_we=1, addr=1022, din=32'd2.
5. Deferred write: change to 6 while cpu_idle=0 for 20 cycles, then to 7 before idle -> load_busy held high throughout; once idle, exactly one write of 32'd7 to 1022.
6. Reset mid-PEND: change pending, cpu_idle=0, assert rst with switch=3'b011 -> pending write dropped; reset writes 32'd3; FSM in IDLE after release.
